// File: rtl/pengo_input_ctrl.sv
// ----------------------------------------------------------------------------
// pengo_input_ctrl
//
// Input front end for the Pengo core. This block turns PS/2 key events and
// MiSTer joystick words into the two active-low input port bytes that the
// core reads. It remaps directions for a rotated screen and removes
// opposing-direction pairs. It also produces coin pulses with a fixed width
// and gap, both timed in frames.
//
// Ports
//   clk         system clock (clk_sys domain)
//   reset       synchronous, active-high reset
//   ps2_key     [10] toggles per event, [9] pressed, [8] extended, [7:0] code
//   joystick_0  P1: [0]R [1]L [2]D [3]U [4]kick [5]start1 [6]start2
//   joystick_1  P2, same layout
//   orient      1 = rotated screen, directions are remapped
//   vblank      core vblank, frame timebase for the coin pulse machines
//   in0         ~{fire1,0,coin1,coin2,R1,L1,D1,U1}
//   in1         ~{fire2,start2,start1,0,R2,L2,D2,U2}
// ----------------------------------------------------------------------------
module pengo_input_ctrl #(
    parameter int COIN_FRAMES = 4,
    parameter int GAP_FRAMES  = 4,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        orient,
    input  logic        vblank,
    output logic [7:0]  in0,
    output logic [7:0]  in1
);

    localparam int K_U1     = 0;
    localparam int K_D1     = 1;
    localparam int K_L1     = 2;
    localparam int K_R1     = 3;
    localparam int K_FIRE1  = 4;
    localparam int K_START1 = 5;
    localparam int K_START2 = 6;
    localparam int K_COIN1  = 7;
    localparam int K_COIN2  = 8;
    localparam int K_U2     = 9;
    localparam int K_D2     = 10;
    localparam int K_L2     = 11;
    localparam int K_R2     = 12;
    localparam int K_FIRE2  = 13;

    // The counters are compared against "last frame" values. A counter can
    // therefore never run past its target and wrap around.
    localparam logic [CNT_W-1:0] COIN_LAST = CNT_W'(COIN_FRAMES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_FRAMES - 1);

    typedef enum logic [1:0] {
        COIN_IDLE,
        COIN_PULSE,
        COIN_GAP
    } coin_state_e;

    logic              old_toggle_q;
    logic              vblank_q;
    logic [13:0]       key_q, key_d;
    logic [1:0]        req_lvl_q, req_lvl_d;
    logic [1:0]        req_edge_q, req_edge_d;
    logic [1:0]        pending_q, pending_d;
    coin_state_e       state_q [2];
    coin_state_e       state_d [2];
    logic [CNT_W-1:0]  cnt_q [2];
    logic [CNT_W-1:0]  cnt_d [2];
    logic [7:0]        in0_q, in0_d;
    logic [7:0]        in1_q, in1_d;

    logic              key_event;
    logic              vb_edge;
    logic              start1, start2, fire1, fire2;
    logic [3:0]        dir1, dir2;
    logic [1:0]        coin_on;

    logic              unused_joy;
    assign unused_joy = ^{joystick_0[15:7], joystick_1[15:7]};

    // The input vector and the result are both packed as {R,L,D,U}. On a
    // rotated screen each direction is taken from its neighbour. After the
    // remap, any pair of opposing directions that are both held is cancelled.
    function automatic logic [3:0] orient_socd(input logic [3:0] raw, input logic rot);
        logic [3:0] d;
        d = rot ? {raw[0], raw[1], raw[3], raw[2]} : raw;
        if (d[0] && d[1]) d[1:0] = 2'b00;
        if (d[2] && d[3]) d[3:2] = 2'b00;
        return d;
    endfunction

    // Key decode. Arrow keys are matched on the scancode alone, so the
    // extended and non-extended forms are treated as the same key. Every
    // other key must match the full 9-bit code. The output bytes are built
    // from the next latch value. This gives key presses the same 1-clock
    // latency as the joystick inputs.
    always_comb begin
        key_event = (ps2_key[10] != old_toggle_q);
        key_d     = key_q;
        if (key_event) begin
            case (ps2_key[7:0])
                8'h75:   key_d[K_U1] = ps2_key[9];
                8'h72:   key_d[K_D1] = ps2_key[9];
                8'h6B:   key_d[K_L1] = ps2_key[9];
                8'h74:   key_d[K_R1] = ps2_key[9];
                default: ;
            endcase
            case (ps2_key[8:0])
                9'h029, 9'h014: key_d[K_FIRE1]  = ps2_key[9];
                9'h005, 9'h016: key_d[K_START1] = ps2_key[9];
                9'h006, 9'h01E: key_d[K_START2] = ps2_key[9];
                9'h02E:         key_d[K_COIN1]  = ps2_key[9];
                9'h036:         key_d[K_COIN2]  = ps2_key[9];
                9'h02D:         key_d[K_U2]     = ps2_key[9];
                9'h02B:         key_d[K_D2]     = ps2_key[9];
                9'h023:         key_d[K_L2]     = ps2_key[9];
                9'h034:         key_d[K_R2]     = ps2_key[9];
                9'h01C:         key_d[K_FIRE2]  = ps2_key[9];
                default: ;
            endcase
        end

        start1 = key_d[K_START1] | joystick_0[5] | joystick_1[5];
        start2 = key_d[K_START2] | joystick_0[6] | joystick_1[6];
        fire1  = key_d[K_FIRE1]  | joystick_0[4];
        fire2  = key_d[K_FIRE2]  | joystick_1[4];

        dir1 = orient_socd({key_d[K_R1] | joystick_0[0], key_d[K_L1] | joystick_0[1],
                            key_d[K_D1] | joystick_0[2], key_d[K_U1] | joystick_0[3]}, orient);
        dir2 = orient_socd({key_d[K_R2] | joystick_1[0], key_d[K_L2] | joystick_1[1],
                            key_d[K_D2] | joystick_1[2], key_d[K_U2] | joystick_1[3]}, orient);

        coin_on = {state_q[1] == COIN_PULSE, state_q[0] == COIN_PULSE};

        in0_d = ~{fire1, 1'b0, coin_on[0], coin_on[1], dir1};
        in1_d = ~{fire2, start2, start1, 1'b0, dir2};

        // A press of either start button also inserts a coin in the coin2
        // slot. The rising edge of each slot's request is registered and is
        // only acted on in the following cycle.
        req_lvl_d  = {key_d[K_COIN2] | start1 | start2, key_d[K_COIN1]};
        req_edge_d = req_lvl_d & ~req_lvl_q;
        vb_edge    = vblank & ~vblank_q;
    end

    // Coin pulse machine for each slot. The counter only advances on the
    // rising edge of vblank. A pulse therefore lasts exactly COIN_FRAMES
    // frames, whatever point in the frame it starts at. Only one request is
    // queued while the slot is busy; any further requests are dropped. If a
    // request arrives in the same cycle that the gap finishes, a new pulse
    // starts at once.
    always_comb begin
        pending_d = pending_q;
        for (int s = 0; s < 2; s++) begin
            state_d[s] = state_q[s];
            cnt_d[s]   = cnt_q[s];
            case (state_q[s])
                COIN_IDLE: begin
                    if (req_edge_q[s]) begin
                        state_d[s] = COIN_PULSE;
                        cnt_d[s]   = '0;
                    end
                end
                COIN_PULSE: begin
                    if (req_edge_q[s]) pending_d[s] = 1'b1;
                    if (vb_edge) begin
                        if (cnt_q[s] >= COIN_LAST) begin
                            state_d[s] = COIN_GAP;
                            cnt_d[s]   = '0;
                        end else begin
                            cnt_d[s] = cnt_q[s] + CNT_W'(1);
                        end
                    end
                end
                COIN_GAP: begin
                    if (vb_edge && (cnt_q[s] >= GAP_LAST)) begin
                        cnt_d[s]     = '0;
                        pending_d[s] = 1'b0;
                        state_d[s]   = (pending_q[s] || req_edge_q[s]) ? COIN_PULSE : COIN_IDLE;
                    end else begin
                        if (vb_edge) cnt_d[s] = cnt_q[s] + CNT_W'(1);
                        if (req_edge_q[s]) pending_d[s] = 1'b1;
                    end
                end
                default: begin
                    state_d[s] = COIN_IDLE;
                    cnt_d[s]   = '0;
                end
            endcase
        end
    end

    // The toggle and vblank history keep tracking during reset. A key event
    // or vblank edge that is already in flight at reset release is therefore
    // not seen as new.
    always_ff @(posedge clk) begin
        old_toggle_q <= ps2_key[10];
        vblank_q     <= vblank;
        if (reset) begin
            key_q      <= '0;
            req_lvl_q  <= '0;
            req_edge_q <= '0;
            pending_q  <= '0;
            in0_q      <= 8'hFF;
            in1_q      <= 8'hFF;
            for (int s = 0; s < 2; s++) begin
                state_q[s] <= COIN_IDLE;
                cnt_q[s]   <= '0;
            end
        end else begin
            key_q      <= key_d;
            req_lvl_q  <= req_lvl_d;
            req_edge_q <= req_edge_d;
            pending_q  <= pending_d;
            in0_q      <= in0_d;
            in1_q      <= in1_d;
            for (int s = 0; s < 2; s++) begin
                state_q[s] <= state_d[s];
                cnt_q[s]   <= cnt_d[s];
            end
        end
    end

    assign in0 = in0_q;
    assign in1 = in1_q;

endmodule

// File: tb/tb_pengo_input_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pengo_input_ctrl
//
// Self-checking bench for pengo_input_ctrl. It contains a behavioural model
// of the port bytes and of the coin pulse timing. The model tracks each key
// as a flag in a table. Each coin slot is tracked as a countdown of the
// pulse and gap frames left, plus a flag for one queued request.
// ----------------------------------------------------------------------------
module tb_pengo_input_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0, joystick_1;
    logic        orient, vblank;
    logic [7:0]  in0, in1;

    pengo_input_ctrl #(.COIN_FRAMES(4), .GAP_FRAMES(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .ps2_key(ps2_key),
        .joystick_0(joystick_0), .joystick_1(joystick_1),
        .orient(orient), .vblank(vblank), .in0(in0), .in1(in1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        cur_rst = 1'b1;
    logic [10:0] cur_key = 11'h400;
    logic [15:0] cur_j0 = '0, cur_j1 = '0;
    logic        cur_orient = 1'b0, cur_vb = 1'b0;
    logic        tgl = 1'b1;
    logic        step_vbr, tb_vbprev = 1'b0;

    int          low_edges [2];
    int          gap_edges [2];
    int          pulses [2];
    logic [1:0]  prev_coin = 2'b00;

    logic [13:0] m_keys = '0;
    logic        m_old = 1'b0, m_vbprev = 1'b0;
    logic [1:0]  m_lvlprev = '0, m_edge = '0, m_queued = '0;
    int          m_pulse [2];
    int          m_gap [2];
    logic [7:0]  exp_in0 = 8'hFF, exp_in1 = 8'hFF;

    localparam logic [8:0] CODES [20] = '{
        9'h075, 9'h175, 9'h072, 9'h16B, 9'h074, 9'h029, 9'h014, 9'h005, 9'h016, 9'h006,
        9'h01E, 9'h02E, 9'h036, 9'h02D, 9'h02B, 9'h023, 9'h034, 9'h01C, 9'h015, 9'h11C
    };

    // Key table index: 0-3 U1/D1/L1/R1, 4 fire1, 5 start1, 6 start2,
    // 7 coin1, 8 coin2, 9-12 U2/D2/L2/R2, 13 fire2.
    function automatic int keyIndex(input logic [8:0] code);
        case (code[7:0])
            8'h75: return 0;
            8'h72: return 1;
            8'h6B: return 2;
            8'h74: return 3;
            default: ;
        endcase
        case (code)
            9'h029, 9'h014: return 4;
            9'h005, 9'h016: return 5;
            9'h006, 9'h01E: return 6;
            9'h02E: return 7;
            9'h036: return 8;
            9'h02D: return 9;
            9'h02B: return 10;
            9'h023: return 11;
            9'h034: return 12;
            9'h01C: return 13;
            default: return -1;
        endcase
    endfunction

    function automatic logic [3:0] modelDirs(input logic u, input logic d, input logic l,
                                             input logic r, input logic o);
        logic nu, nd, nl, nr;
        if (o) begin nu = l; nd = r; nl = d; nr = u; end
        else   begin nu = u; nd = d; nl = l; nr = r; end
        if (nu && nd) begin nu = 1'b0; nd = 1'b0; end
        if (nl && nr) begin nl = 1'b0; nr = 1'b0; end
        return {nr, nl, nd, nu};
    endfunction

    // Compute the outputs the DUT must show after the next clock edge,
    // using the inputs that are being driven now.
    task automatic modelStep();
        int idx;
        logic s1, s2, f1, f2, vbe, ev;
        logic [3:0] d1, d2;
        logic [1:0] lvl, coin;
        if (cur_rst) begin
            m_keys = '0; m_old = cur_key[10]; m_vbprev = cur_vb;
            m_lvlprev = '0; m_edge = '0; m_queued = '0;
            m_pulse[0] = 0; m_pulse[1] = 0; m_gap[0] = 0; m_gap[1] = 0;
            exp_in0 = 8'hFF; exp_in1 = 8'hFF;
            return;
        end
        if (cur_key[10] != m_old) begin
            idx = keyIndex(cur_key[8:0]);
            if (idx >= 0) m_keys[idx] = cur_key[9];
        end
        m_old = cur_key[10];
        s1 = m_keys[5] | cur_j0[5] | cur_j1[5];
        s2 = m_keys[6] | cur_j0[6] | cur_j1[6];
        f1 = m_keys[4] | cur_j0[4];
        f2 = m_keys[13] | cur_j1[4];
        d1 = modelDirs(m_keys[0] | cur_j0[3], m_keys[1] | cur_j0[2],
                       m_keys[2] | cur_j0[1], m_keys[3] | cur_j0[0], cur_orient);
        d2 = modelDirs(m_keys[9] | cur_j1[3], m_keys[10] | cur_j1[2],
                       m_keys[11] | cur_j1[1], m_keys[12] | cur_j1[0], cur_orient);
        coin = {m_pulse[1] > 0, m_pulse[0] > 0};
        exp_in0 = ~{f1, 1'b0, coin[0], coin[1], d1};
        exp_in1 = ~{f2, s2, s1, 1'b0, d2};
        lvl = {m_keys[8] | s1 | s2, m_keys[7]};
        vbe = cur_vb & ~m_vbprev;
        m_vbprev = cur_vb;
        for (int s = 0; s < 2; s++) begin
            ev = m_edge[s];
            m_edge[s] = lvl[s] & ~m_lvlprev[s];
            m_lvlprev[s] = lvl[s];
            if (m_pulse[s] > 0) begin
                if (ev) m_queued[s] = 1'b1;
                if (vbe) begin
                    m_pulse[s]--;
                    if (m_pulse[s] == 0) m_gap[s] = 4;
                end
            end else if (m_gap[s] > 0) begin
                if (vbe && m_gap[s] == 1) begin
                    m_gap[s] = 0;
                    if (m_queued[s] || ev) m_pulse[s] = 4;
                    m_queued[s] = 1'b0;
                end else begin
                    if (vbe) m_gap[s]--;
                    if (ev) m_queued[s] = 1'b1;
                end
            end else if (ev) begin
                m_pulse[s] = 4;
            end
        end
    endtask

    task automatic checkOutput();
        checks++;
        if (in0 !== exp_in0) begin
            failures++;
            $display("[TB] FAIL in0 at %0t: got %h expected %h", $time, in0, exp_in0);
        end
        checks++;
        if (in1 !== exp_in1) begin
            failures++;
            $display("[TB] FAIL in1 at %0t: got %h expected %h", $time, in1, exp_in1);
        end
    endtask

    task automatic checkLiteral(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus();
        logic [1:0] c;
        reset = cur_rst; ps2_key = cur_key; joystick_0 = cur_j0; joystick_1 = cur_j1;
        orient = cur_orient; vblank = cur_vb;
        step_vbr = cur_vb & ~tb_vbprev;
        tb_vbprev = cur_vb;
        modelStep();
        @(posedge clk);
        @(negedge clk);
        checkOutput();
        c = {~in0[4], ~in0[5]};
        for (int s = 0; s < 2; s++) begin
            if (c[s] && step_vbr) low_edges[s]++;
            if (!c[s] && step_vbr && pulses[s] > 0) gap_edges[s]++;
            if (c[s] && !prev_coin[s]) pulses[s]++;
        end
        prev_coin = c;
    endtask

    task automatic sendKey(input logic [8:0] code, input logic pressed);
        tgl = ~tgl;
        cur_key = {tgl, pressed, code};
        applyStimulus();
    endtask

    task automatic runFrames(input int n);
        for (int f = 0; f < n; f++) begin
            for (int c = 0; c < 8; c++) begin
                cur_vb = (c < 2);
                applyStimulus();
            end
        end
    endtask

    task automatic clearCounters();
        for (int s = 0; s < 2; s++) begin
            low_edges[s] = 0; gap_edges[s] = 0; pulses[s] = 0;
        end
    endtask

    initial begin
        clearCounters();
        m_pulse[0] = 0; m_pulse[1] = 0; m_gap[0] = 0; m_gap[1] = 0;

        $display("[TB] reset with toggle bit high");
        for (int i = 0; i < 3; i++) applyStimulus();
        checkLiteral("reset_in0", int'(in0), 255);
        checkLiteral("reset_in1", int'(in1), 255);
        cur_rst = 1'b0;
        applyStimulus();
        applyStimulus();
        checkLiteral("post_reset_in0", int'(in0), 255);
        checkLiteral("post_reset_in1", int'(in1), 255);

        $display("[TB] extended up arrow press and release");
        sendKey(9'h175, 1'b1);
        checkLiteral("u1_pressed", int'(in0[0]), 0);
        sendKey(9'h175, 1'b0);
        checkLiteral("u1_released", int'(in0[0]), 1);

        $display("[TB] orientation remap and opposing cancel");
        cur_orient = 1'b1; cur_j0 = 16'h0002;
        applyStimulus();
        checkLiteral("rot_left_is_up", int'(in0[0]), 0);
        sendKey(9'h072, 1'b1);
        cur_j0 = 16'h0003;
        applyStimulus();
        checkLiteral("rot_socd_dirs", int'(in0[3:0]), 4'b1011);
        cur_j0 = '0; cur_orient = 1'b0;
        sendKey(9'h072, 1'b0);

        $display("[TB] coin1 pulse width");
        clearCounters();
        sendKey(9'h02E, 1'b1);
        runFrames(10);
        checkLiteral("coin1_pulse_frames", low_edges[0], 4);
        checkLiteral("coin1_pulse_count", pulses[0], 1);
        checkLiteral("coin1_gap_at_least_4", int'(gap_edges[0] >= 4), 1);
        sendKey(9'h02E, 1'b0);

        $display("[TB] coin2 queue of one");
        clearCounters();
        for (int k = 0; k < 3; k++) begin
            sendKey(9'h036, 1'b1);
            runFrames(1);
            sendKey(9'h036, 1'b0);
            runFrames(1);
        end
        runFrames(16);
        checkLiteral("coin2_pulse_count", pulses[1], 2);
        checkLiteral("coin2_pulse_frames", low_edges[1], 8);

        $display("[TB] reset during coin pulse");
        clearCounters();
        sendKey(9'h036, 1'b1);
        runFrames(2);
        checkLiteral("coin2_active_before_reset", int'(in0[4]), 0);
        cur_rst = 1'b1;
        applyStimulus();
        checkLiteral("coin2_cleared_by_reset", int'(in0[4]), 1);
        cur_rst = 1'b0;
        applyStimulus();
        clearCounters();
        sendKey(9'h036, 1'b0);
        sendKey(9'h036, 1'b1);
        runFrames(8);
        checkLiteral("coin2_after_reset_frames", low_edges[1], 4);
        checkLiteral("coin2_after_reset_count", pulses[1], 1);
        sendKey(9'h036, 1'b0);

        $display("[TB] randomized traffic");
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if ($urandom_range(7) == 0) begin
                tgl = ~tgl;
                cur_key = {tgl, 1'($urandom_range(1)), CODES[$urandom_range(19)]};
            end
            if ($urandom_range(15) == 0) cur_j0 = 16'($urandom & $urandom & $urandom);
            if ($urandom_range(15) == 0) cur_j1 = 16'($urandom & $urandom & $urandom);
            if ($urandom_range(63) == 0) cur_orient = ~cur_orient;
            cur_vb  = ((cyc % 10) < 2);
            cur_rst = ($urandom_range(299) == 0);
            applyStimulus();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
